hd44780_controller: RTL and testbench

HD44780_CONTROLLER -- requirements
Module: hd44780_controller

---
 rtl/hd44780_pkg.sv | 46 ++++
 rtl/hd44780_nybble_sender.sv | 98 +++++++++
 rtl/hd44780_syscon.sv | 34 +++
 rtl/hd44780_controller.sv | 198 +++++++++++++++++++
 tb/tb_hd44780_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hd44780_pkg.sv
// rtl/hd44780_pkg.sv - shared states, init command list and timing defaults for the HD44780 controller
package hd44780_pkg;

  typedef enum logic [3:0] {
    ST_POWERUP,
    ST_INIT_NYB,
    ST_INIT_WAIT,
    ST_INIT_BYTES,
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_E_HOLD,
    ST_GAP,
    ST_EXEC_WAIT
  } state_t;

  // Function set 4-bit/2-line, display on, clear, entry mode increment
  localparam int unsigned INIT_CMD_NUM = 4;
  localparam logic [7:0] INIT_CMDS [INIT_CMD_NUM] = '{8'h28, 8'h0C, 8'h01, 8'h06};

  localparam int unsigned DEF_POWERUP_CYC = 720000;
  localparam int unsigned DEF_INIT1_CYC   = 197000;
  localparam int unsigned DEF_INIT2_CYC   = 4800;
  localparam int unsigned DEF_E_SETUP_CYC = 3;
  localparam int unsigned DEF_E_HIGH_CYC  = 12;
  localparam int unsigned DEF_E_HOLD_CYC  = 3;
  localparam int unsigned DEF_NYB_GAP_CYC = 48;
  localparam int unsigned DEF_CMD_CYC     = 2016;
  localparam int unsigned DEF_CLEAR_CYC   = 78720;
  localparam int unsigned DEF_BLINK_BITS  = 24;

  // A zero-length wait still occupies one cycle
  function automatic int unsigned eff_cyc(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear display and return home need the long execution wait
  function automatic logic is_clear_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
  endfunction

endpackage

// File: rtl/hd44780_nybble_sender.sv
// rtl/hd44780_nybble_sender.sv - drives one nybble onto the LCD bus with setup, E pulse and hold
module hd44780_nybble_sender
  import hd44780_pkg::*;
#(
  parameter int unsigned E_SETUP_CYC = DEF_E_SETUP_CYC,
  parameter int unsigned E_HIGH_CYC  = DEF_E_HIGH_CYC,
  parameter int unsigned E_HOLD_CYC  = DEF_E_HOLD_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nybble,
  output logic       done,
  output logic       o_rs,
  output logic [3:0] o_lcd_data,
  output logic       o_e,
  output state_t     next_phase
);

  localparam int unsigned CNT_MAX = max_u(eff_cyc(E_SETUP_CYC),
                                          max_u(eff_cyc(E_HIGH_CYC), eff_cyc(E_HOLD_CYC)));
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(eff_cyc(E_SETUP_CYC) - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(eff_cyc(E_HIGH_CYC) - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(eff_cyc(E_HOLD_CYC) - 1);

  state_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [3:0]       data_q, data_d;
  logic             e_q, e_d;

  // Phase sequencing; bus data is captured only when idle so it cannot move under E
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 1'b1;
    rs_d    = rs_q;
    data_d  = data_q;
    case (phase_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          phase_d = ST_SETUP;
          rs_d    = rs;
          data_d  = nybble;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          phase_d = ST_E_HIGH;
          cnt_d   = '0;
        end
      end
      ST_E_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          phase_d = ST_E_HOLD;
          cnt_d   = '0;
        end
      end
      ST_E_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          phase_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        phase_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    e_d = (phase_d == ST_E_HIGH);
  end

  // Phase, counter and bus registers; reset drops E asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= ST_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 4'h0;
      e_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      e_q     <= e_d;
    end
  end

  assign done       = (phase_q == ST_E_HOLD) && (cnt_q == HOLD_LAST);
  assign next_phase = phase_d;
  assign o_rs       = rs_q;
  assign o_lcd_data = data_q;
  assign o_e        = e_q;

endmodule

// File: rtl/hd44780_syscon.sv
// rtl/hd44780_syscon.sv - clock pass-through and power-on reset generator for the controller
module hd44780_syscon #(
  parameter int unsigned RST_CYC = 16
) (
  input  logic i_clk,
  output logic CLK_O,
  output logic RST_O
);

  localparam int unsigned CW = $clog2(RST_CYC + 1);
  localparam logic [CW-1:0] CNT_END = CW'(RST_CYC);

  // Power-up values come from the configuration bitstream; there is no reset input here
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;
  logic          rst_q = 1'b1;
  logic          rst_d;

  // Count up to RST_CYC and hold there; reset is high until the count is reached
  always_comb begin
    cnt_d = (cnt_q == CNT_END) ? cnt_q : cnt_q + 1'b1;
    rst_d = (cnt_d != CNT_END);
  end

  // Counter and registered reset output
  always_ff @(posedge i_clk) begin
    cnt_q <= cnt_d;
    rst_q <= rst_d;
  end

  assign CLK_O = i_clk;
  assign RST_O = rst_q;

endmodule

// File: rtl/hd44780_controller.sv
// rtl/hd44780_controller.sv - HD44780 4-bit bus controller with power-up init and byte requests
module hd44780_controller
  import hd44780_pkg::*;
#(
  parameter int unsigned POWERUP_CYC = DEF_POWERUP_CYC,
  parameter int unsigned INIT1_CYC   = DEF_INIT1_CYC,
  parameter int unsigned INIT2_CYC   = DEF_INIT2_CYC,
  parameter int unsigned E_SETUP_CYC = DEF_E_SETUP_CYC,
  parameter int unsigned E_HIGH_CYC  = DEF_E_HIGH_CYC,
  parameter int unsigned E_HOLD_CYC  = DEF_E_HOLD_CYC,
  parameter int unsigned NYB_GAP_CYC = DEF_NYB_GAP_CYC,
  parameter int unsigned CMD_CYC     = DEF_CMD_CYC,
  parameter int unsigned CLEAR_CYC   = DEF_CLEAR_CYC,
  parameter int unsigned BLINK_BITS  = DEF_BLINK_BITS
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic       i_rs,
  input  logic [7:0] i_lcd_data,
  output logic       busy,
  output logic       alive_led,
  output logic       o_rs,
  output logic [3:0] o_lcd_data,
  output logic       o_e
);

  localparam int unsigned WAIT_MAX =
    max_u(max_u(eff_cyc(POWERUP_CYC), eff_cyc(INIT1_CYC)),
          max_u(max_u(eff_cyc(INIT2_CYC), eff_cyc(NYB_GAP_CYC)),
                max_u(eff_cyc(CMD_CYC), eff_cyc(CLEAR_CYC))));
  localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] POWERUP_LAST = WCNT_W'(eff_cyc(POWERUP_CYC) - 1);
  localparam logic [WCNT_W-1:0] INIT1_LAST   = WCNT_W'(eff_cyc(INIT1_CYC) - 1);
  localparam logic [WCNT_W-1:0] INIT2_LAST   = WCNT_W'(eff_cyc(INIT2_CYC) - 1);
  localparam logic [WCNT_W-1:0] GAP_LAST     = WCNT_W'(eff_cyc(NYB_GAP_CYC) - 1);
  localparam logic [WCNT_W-1:0] CMD_LAST     = WCNT_W'(eff_cyc(CMD_CYC) - 1);
  localparam logic [WCNT_W-1:0] CLEAR_LAST   = WCNT_W'(eff_cyc(CLEAR_CYC) - 1);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              lo_q, lo_d;
  logic              init_done_q, init_done_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;

  logic [WCNT_W-1:0] wait_last;
  logic              wait_done;
  logic              snd_start;
  logic              snd_rs;
  logic [3:0]        snd_nyb;
  logic              snd_done;
  state_t            snd_next;

  hd44780_nybble_sender #(
    .E_SETUP_CYC (E_SETUP_CYC),
    .E_HIGH_CYC  (E_HIGH_CYC),
    .E_HOLD_CYC  (E_HOLD_CYC)
  ) u_sender (
    .clk        (CLK_I),
    .rst        (RST_I),
    .start      (snd_start),
    .rs         (snd_rs),
    .nybble     (snd_nyb),
    .done       (snd_done),
    .o_rs       (o_rs),
    .o_lcd_data (o_lcd_data),
    .o_e        (o_e),
    .next_phase (snd_next)
  );

  // Terminal count for whichever wait the current state is timing
  always_comb begin
    wait_last = '0;
    case (state_q)
      ST_POWERUP:   wait_last = POWERUP_LAST;
      ST_INIT_WAIT: wait_last = (idx_q == 2'd0) ? INIT1_LAST : INIT2_LAST;
      ST_GAP:       wait_last = GAP_LAST;
      ST_EXEC_WAIT: wait_last = is_clear_cmd(rs_q, data_q) ? CLEAR_LAST : CMD_LAST;
      default:      wait_last = '0;
    endcase
    wait_done = (wcnt_q == wait_last);
  end

  // Sequencer: init nybbles, init bytes, then byte requests from IDLE
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    snd_start   = 1'b0;
    snd_rs      = rs_q;
    snd_nyb     = data_q[7:4];
    case (state_q)
      ST_POWERUP: begin
        if (wait_done) begin
          snd_start = 1'b1;
          snd_rs    = 1'b0;
          snd_nyb   = 4'h3;
          idx_d     = 2'd0;
          state_d   = ST_INIT_NYB;
        end
      end
      ST_INIT_NYB: begin
        if (snd_done) state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (wait_done) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = ST_INIT_BYTES;
          end else begin
            idx_d     = idx_q + 2'd1;
            snd_start = 1'b1;
            snd_rs    = 1'b0;
            snd_nyb   = (idx_q == 2'd2) ? 4'h2 : 4'h3;
            state_d   = ST_INIT_NYB;
          end
        end
      end
      ST_INIT_BYTES: begin
        rs_d      = 1'b0;
        data_d    = INIT_CMDS[idx_q];
        snd_start = 1'b1;
        snd_rs    = 1'b0;
        snd_nyb   = INIT_CMDS[idx_q][7:4];
        lo_d      = 1'b0;
        state_d   = ST_SETUP;
        if (idx_q == 2'(INIT_CMD_NUM - 1)) init_done_d = 1'b1;
        else                              idx_d       = idx_q + 2'd1;
      end
      ST_IDLE: begin
        if (STB_I) begin
          rs_d      = i_rs;
          data_d    = i_lcd_data;
          snd_start = 1'b1;
          snd_rs    = i_rs;
          snd_nyb   = i_lcd_data[7:4];
          lo_d      = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP, ST_E_HIGH, ST_E_HOLD: begin
        if (snd_done) state_d = lo_q ? ST_EXEC_WAIT : ST_GAP;
        else          state_d = snd_next;
      end
      ST_GAP: begin
        if (wait_done) begin
          snd_start = 1'b1;
          snd_nyb   = data_q[3:0];
          lo_d      = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_EXEC_WAIT: begin
        if (wait_done) state_d = init_done_q ? ST_IDLE : ST_INIT_BYTES;
      end
      default: state_d = ST_POWERUP;
    endcase
    wcnt_d  = (state_d != state_q || wait_done) ? '0 : wcnt_q + 1'b1;
    busy_d  = (state_d != ST_IDLE);
    blink_d = blink_q + 1'b1;
  end

  // All controller state; reset restarts the full init sequence
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= ST_POWERUP;
      wcnt_q      <= '0;
      idx_q       <= 2'd0;
      lo_q        <= 1'b0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      busy_q      <= 1'b1;
      blink_q     <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      blink_q     <= blink_d;
    end
  end

  assign busy      = busy_q;
  assign alive_led = blink_q[BLINK_BITS-1];

endmodule

// File: tb/tb_hd44780_controller.sv
// tb/tb_hd44780_controller.sv - scoreboard bench for the HD44780 controller and its syscon
module tb_hd44780_controller;
  import hd44780_pkg::*;

  localparam int unsigned P_POWERUP = 20;
  localparam int unsigned P_INIT1   = 10;
  localparam int unsigned P_INIT2   = 5;
  localparam int unsigned P_SETUP   = 1;
  localparam int unsigned P_HIGH    = 2;
  localparam int unsigned P_HOLD    = 1;
  localparam int unsigned P_GAP     = 2;
  localparam int unsigned P_CMD     = 8;
  localparam int unsigned P_CLEAR   = 16;
  localparam int unsigned P_BLINK   = 6;

  localparam int TAIL_CMD = P_HOLD + P_CMD;
  localparam int TAIL_CLR = P_HOLD + P_CLEAR;
  localparam int GAP_EXP  = P_HOLD + P_GAP + P_SETUP;

  logic       clk = 1'b0;
  logic       RST_I;
  logic       STB_I;
  logic       i_rs;
  logic [7:0] i_lcd_data;
  logic       busy;
  logic       alive_led;
  logic       o_rs;
  logic [3:0] o_lcd_data;
  logic       o_e;
  logic       sc_clk;
  logic       sc_rst;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  int gap_cyc = 0;
  logic       prev_e = 1'b0;
  logic [4:0] rise_val = '0;
  logic [4:0] exp_q [$];
  logic [3:0] init_nybs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

  always #5 clk = ~clk;

  hd44780_controller #(
    .POWERUP_CYC (P_POWERUP),
    .INIT1_CYC   (P_INIT1),
    .INIT2_CYC   (P_INIT2),
    .E_SETUP_CYC (P_SETUP),
    .E_HIGH_CYC  (P_HIGH),
    .E_HOLD_CYC  (P_HOLD),
    .NYB_GAP_CYC (P_GAP),
    .CMD_CYC     (P_CMD),
    .CLEAR_CYC   (P_CLEAR),
    .BLINK_BITS  (P_BLINK)
  ) dut (
    .CLK_I      (clk),
    .RST_I      (RST_I),
    .STB_I      (STB_I),
    .i_rs       (i_rs),
    .i_lcd_data (i_lcd_data),
    .busy       (busy),
    .alive_led  (alive_led),
    .o_rs       (o_rs),
    .o_lcd_data (o_lcd_data),
    .o_e        (o_e)
  );

  hd44780_syscon #(.RST_CYC(16)) u_syscon (
    .i_clk (clk),
    .CLK_O (sc_clk),
    .RST_O (sc_rst)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_init();
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_nybs[i]});
  endtask

  task automatic wait_busy_low(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
    check("busy_low_timeout", busy, 1'b0);
  endtask

  task automatic finish_init();
    wait_busy_low(2000);
    check("init_all_nybbles_before_idle", exp_q.size(), 0);
    check("state_idle_after_init", dut.state_q, ST_IDLE);
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input int tail, input bit poke);
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
    STB_I = 1'b1; i_rs = rs; i_lcd_data = d;
    tick();
    STB_I = 1'b0;
    check("busy_after_stb", busy, 1'b1);
    if (poke) begin
      tick();
      tick();
      STB_I = 1'b1; i_rs = ~rs; i_lcd_data = ~d;
      tick();
      STB_I = 1'b0;
    end
    wait_busy_low(500);
    check("byte_nybbles_drained", exp_q.size(), 0);
    check("busy_tail_cycles", cyc - fall_cyc, tail);
    check("nybble_gap_cycles", gap_cyc, GAP_EXP);
  endtask

  // Pulse monitor: each E falling edge pops one expected {rs, nybble}
  always @(negedge clk) begin
    logic [4:0] e;
    cyc++;
    if (RST_I) begin
      prev_e = 1'b0;
    end else begin
      if (o_e && !prev_e) begin
        rise_cyc = cyc;
        rise_val = {o_rs, o_lcd_data};
        gap_cyc  = cyc - fall_cyc;
      end
      if (!o_e && prev_e) begin
        check("pulse_was_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("nybble_at_e_rise", rise_val, e);
          check("nybble_at_e_fall", {o_rs, o_lcd_data}, e);
          check("e_high_width", cyc - rise_cyc, P_HIGH);
        end
        fall_cyc = cyc;
      end
      prev_e = o_e;
    end
  end

  initial begin
    int n;
    RST_I = 1'b1; STB_I = 1'b0; i_rs = 1'b0; i_lcd_data = 8'h00;

    repeat (15) tick();
    check("syscon_rst_high", sc_rst, 1'b1);
    check("rst_o_e", o_e, 1'b0);
    check("rst_o_rs", o_rs, 1'b0);
    check("rst_o_lcd_data", o_lcd_data, 4'h0);
    check("rst_busy", busy, 1'b1);
    check("rst_alive_led", alive_led, 1'b0);
    tick();
    check("syscon_rst_released", sc_rst, 1'b0);

    push_init();
    RST_I = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k == 25) begin STB_I = 1'b1; i_rs = 1'b1; i_lcd_data = 8'h99; end
      if (k == 26) STB_I = 1'b0;
    end
    check("alive_before_msb", alive_led, 1'b0);
    tick();
    check("alive_at_msb", alive_led, 1'b1);
    check("busy_during_init", busy, 1'b1);
    finish_init();

    send(1'b0, 8'h6D, TAIL_CMD, 1'b0);
    send(1'b1, 8'hA5, TAIL_CMD, 1'b0);
    send(1'b0, 8'h40, TAIL_CMD, 1'b1);
    send(1'b0, 8'h01, TAIL_CLR, 1'b0);
    send(1'b1, 8'h01, TAIL_CMD, 1'b0);
    send(1'b0, 8'h03, TAIL_CLR, 1'b1);

    exp_q.push_back({1'b0, 4'h6});
    exp_q.push_back({1'b0, 4'hD});
    STB_I = 1'b1; i_rs = 1'b0; i_lcd_data = 8'h6D;
    tick();
    STB_I = 1'b0;
    n = 0;
    while (o_e !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("e_high_before_reset", o_e, 1'b1);
    #2;
    RST_I = 1'b1;
    #1;
    check("async_reset_clears_e", o_e, 1'b0);
    exp_q.delete();
    tick();
    tick();
    check("rst2_busy", busy, 1'b1);
    check("rst2_o_rs", o_rs, 1'b0);
    check("rst2_o_lcd_data", o_lcd_data, 4'h0);
    check("rst2_alive_led", alive_led, 1'b0);
    push_init();
    RST_I = 1'b0;
    tick();
    check("busy_during_reinit", busy, 1'b1);
    finish_init();

    send(1'b0, 8'h02, TAIL_CLR, 1'b0);
    repeat (10) tick();
    check("no_stray_pulses", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
